bayer_window_3x3: RTL and testbench



---
 rtl/demosaic_pkg.sv | 18 +
 rtl/line_ram.sv | 27 ++
 rtl/bayer_window_3x3.sv | 164 ++++++++++++++++
 tb/tb_bayer_window_3x3.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_pkg.sv
// Shared pixel/window types for the demosaic front end.
// Window rows are ordered oldest-first; phase codes name the 2x2 tile seen at {row parity, col parity}.
package demosaic_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    // [row][col][bit]; [0][0] is the oldest row, leftmost column and lands in the LSBs.
    typedef logic [2:0][2:0][PIX_W-1:0] window_t;

    typedef enum logic [1:0] {
        RGGB = 2'b00,
        GRBG = 2'b01,
        GBRG = 2'b10,
        BGGR = 2'b11
    } bayer_phase_e;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer with a registered read port.
// Holds one full image row; contents are never reset.
module line_ram #(
    parameter int DW = 12,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    (* ram_style = "bram" *) logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bayer_window_3x3.sv
// Streaming 3x3 Bayer neighbourhood generator: raster pixels in, one registered window per interior pixel out.
// Two line buffers supply the previous rows; the window appears two edges after the pixel that completes it.
module bayer_window_3x3
    import demosaic_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic             win_valid,
    output logic [WIN_W-1:0] win_data,
    output logic [1:0]       win_phase,
    output logic             win_sof,
    output logic             win_eol,
    output logic             overflow
);

    localparam logic [ADDR_BITS-1:0] COL_MAX = '1;

    logic [ADDR_BITS-1:0] col_q;
    logic [ADDR_BITS-1:0] eff_col;
    logic [15:0]          row_q;
    logic [15:0]          eff_row;
    logic                 ovf_line_q;
    logic                 ovf_line_eff;
    logic                 col_sat;

    logic                 s1_valid;
    logic [PIX_W-1:0]     s1_data;
    logic [ADDR_BITS-1:0] s1_col;
    logic [15:0]          s1_row;
    logic                 s1_eol;
    logic                 s1_wen;

    logic [PIX_W-1:0]     rd_a;
    logic [PIX_W-1:0]     rd_b;

    logic                 s2_valid;
    logic [ADDR_BITS-1:0] s2_col;
    logic [15:0]          s2_row;
    logic                 s2_eol;
    window_t              win_q;

    // A start-of-frame pixel takes position (0,0) regardless of where the counters were.
    always_comb begin
        eff_col      = in_sof ? '0 : col_q;
        eff_row      = in_sof ? '0 : row_q;
        ovf_line_eff = ovf_line_q && !in_sof;
        col_sat      = !in_eol && (eff_col == COL_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            ovf_line_q <= 1'b0;
            overflow   <= 1'b0;
        end else if (in_valid) begin
            if (in_eol) begin
                col_q      <= '0;
                row_q      <= eff_row + 16'd1;
                ovf_line_q <= 1'b0;
            end else if (col_sat) begin
                col_q      <= COL_MAX;
                row_q      <= eff_row;
                ovf_line_q <= 1'b1;
                overflow   <= 1'b1;
            end else begin
                col_q      <= eff_col + ADDR_BITS'(1);
                row_q      <= eff_row;
                ovf_line_q <= ovf_line_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_eol   <= 1'b0;
            s1_wen   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_col  <= eff_col;
                s1_row  <= eff_row;
                s1_eol  <= in_eol;
                s1_wen  <= !ovf_line_eff;
            end
        end
    end

    // lineA carries row-1, lineB carries row-2 (fed from lineA's read port).
    line_ram #(.DW(PIX_W), .AW(ADDR_BITS)) u_line_a (
        .clk   (clk),
        .we    (s1_valid && s1_wen),
        .waddr (s1_col),
        .wdata (s1_data),
        .re    (in_valid),
        .raddr (eff_col),
        .rdata (rd_a)
    );

    line_ram #(.DW(PIX_W), .AW(ADDR_BITS)) u_line_b (
        .clk   (clk),
        .we    (s1_valid && s1_wen),
        .waddr (s1_col),
        .wdata (rd_a),
        .re    (in_valid),
        .raddr (eff_col),
        .rdata (rd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_col   <= '0;
            s2_row   <= '0;
            s2_eol   <= 1'b0;
            win_q    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_col <= s1_col;
                s2_row <= s1_row;
                s2_eol <= s1_eol;
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= rd_b;
                win_q[1][2] <= rd_a;
                win_q[2][2] <= s1_data;
            end
        end
    end

    // Window centre is one row up and one column left of the newest pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_sof   <= 1'b0;
            win_eol   <= 1'b0;
            win_data  <= '0;
            win_phase <= '0;
        end else begin
            win_valid <= s2_valid && (s2_row >= 16'd2) && (s2_col >= ADDR_BITS'(2));
            win_sof   <= s2_valid && (s2_row == 16'd2) && (s2_col == ADDR_BITS'(2));
            win_eol   <= s2_valid && s2_eol && (s2_row >= 16'd2);
            if (s2_valid) begin
                win_data  <= win_q;
                win_phase <= {~s2_row[0], ~s2_col[0]};
            end
        end
    end

endmodule

// File: tb/tb_bayer_window_3x3.sv
// Self-checking bench for bayer_window_3x3: a frame-array reference model predicts every output cycle.
// Windows are rebuilt from stored frame pixels, not from line buffers or pipeline stages.
module tb_bayer_window_3x3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [11:0]  in_data;
    logic         in_sof;
    logic         in_eol;
    logic         win_valid;
    logic [107:0] win_data;
    logic [1:0]   win_phase;
    logic         win_sof;
    logic         win_eol;
    logic         overflow;

    bayer_window_3x3 #(.ADDR_BITS(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .win_valid (win_valid),
        .win_data  (win_data),
        .win_phase (win_phase),
        .win_sof   (win_sof),
        .win_eol   (win_eol),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [107:0] data;
        bit           known;
        logic [1:0]   phase;
        bit           sof;
        bit           eol;
    } exp_t;

    exp_t exp_q[$];
    int   pix [16][2048];
    int   m_row, m_col;
    bit   m_ovfl, m_ovf;
    int   cyc;
    int   n_win;
    int   n_pass, n_total;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the frame model, then check the outputs just after the edge.
    task automatic step(input bit v, input logic [11:0] d, input bit s, input bit e, input bit rn);
        int   r, c, p;
        bit   wr;
        exp_t x;
        rst_n = rn; in_valid = v; in_data = d; in_sof = s; in_eol = e;
        @(posedge clk);
        cyc++;
        if (!rn) begin
            exp_q.delete();
            m_row = 0; m_col = 0; m_ovfl = 0; m_ovf = 0;
        end else if (v) begin
            r  = s ? 0 : m_row;
            c  = s ? 0 : m_col;
            wr = !(m_ovfl && !s);
            if (s) foreach (pix[i, j]) pix[i][j] = -1;
            if (c == 0) for (int j = 0; j < 2048; j++) pix[r % 16][j] = -1;
            if (wr) pix[r % 16][c] = int'(d);
            if (r >= 2 && c >= 2) begin
                x.due = cyc + 2; x.known = 1; x.data = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++) begin
                        p = pix[(r - 2 + rr) % 16][c - 2 + cc];
                        if (p < 0) x.known = 0;
                        else x.data[(rr*3+cc)*12 +: 12] = 12'(p);
                    end
                x.phase[1] = ((r - 1) % 2) == 1;
                x.phase[0] = ((c - 1) % 2) == 1;
                x.sof = (r == 2 && c == 2);
                x.eol = e;
                exp_q.push_back(x);
            end
            if (e) begin
                m_col = 0; m_row = r + 1; m_ovfl = 0;
            end else if (c == 2047) begin
                m_col = 2047; m_row = r; m_ovfl = 1; m_ovf = 1;
            end else begin
                m_col = c + 1; m_row = r; m_ovfl = m_ovfl && !s;
            end
        end
        #1;
        if (!rn) begin
            chk("rst_data", win_data, 0);
            chk("rst_phase", win_phase, 0);
            chk("rst_sof", win_sof, 0);
            chk("rst_eol", win_eol, 0);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            x = exp_q.pop_front();
            chk("win_valid", win_valid, 1);
            chk("win_sof", win_sof, x.sof);
            chk("win_eol", win_eol, x.eol);
            chk("win_phase", win_phase, x.phase);
            if (x.known) chk("win_data", win_data, x.data);
        end else begin
            chk("win_valid_idle", win_valid, 0);
        end
        chk("overflow", overflow, m_ovf);
        if (win_valid === 1'b1) n_win++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 12'($urandom), 1'($urandom), 1'($urandom), 1);
    endtask

    // gap >= 100 inserts exactly one idle cycle after every pixel; otherwise gap is a percentage.
    task automatic send_frame(input int w, input int h, input int gap, input bit pat, input int max_pix);
        int n;
        n = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (max_pix >= 0 && n >= max_pix) return;
                if (gap < 100)
                    while ($urandom_range(99) < gap) step(0, 12'($urandom), 0, 0, 1);
                step(1, pat ? 12'(r*16 + c) : 12'($urandom), (r == 0 && c == 0), (c == w - 1), 1);
                if (gap >= 100) step(0, 12'($urandom), 0, 0, 1);
                n++;
            end
    endtask

    initial begin
        int w, h;
        n_pass = 0; n_total = 0; cyc = 0; n_win = 0;
        m_row = 0; m_col = 0; m_ovfl = 0; m_ovf = 0;
        foreach (pix[i, j]) pix[i][j] = -1;

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(2);

        n_win = 0;
        send_frame(4, 4, 0, 1, -1);
        idle(4);
        chk("win_count_4x4", n_win, 4);

        n_win = 0;
        send_frame(4, 4, 100, 1, -1);
        idle(4);
        chk("win_count_toggle", n_win, 4);

        n_win = 0;
        send_frame(3, 5, 0, 0, -1);
        idle(4);
        chk("win_count_3wide", n_win, 3);

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(3, 24);
            h = $urandom_range(3, 7);
            n_win = 0;
            send_frame(w, h, $urandom_range(0, 60), 0, -1);
            idle(3);
            chk("win_count_rand", n_win, (w - 2) * (h - 2));
        end

        send_frame(6, 6, 20, 0, 6*3 + 2);
        step(0, 0, 0, 0, 0);
        n_win = 0;
        send_frame(6, 6, 0, 1, -1);
        idle(4);
        chk("win_count_after_rst", n_win, 16);

        send_frame(8, 5, 10, 0, 8 + 3);
        n_win = 0;
        send_frame(5, 4, 0, 0, -1);
        idle(4);
        chk("win_count_resof", n_win, 6);

        n_win = 0;
        step(1, 12'($urandom), 1, 1, 1);
        for (int r = 1; r < 5; r++)
            for (int c = 0; c < 5; c++) step(1, 12'($urandom), 0, (c == 4), 1);
        idle(4);
        chk("win_count_1pix_line", n_win, 9);

        for (int c = 0; c < 2048; c++) step(1, 12'($urandom), (c == 0), (c == 2047), 1);
        chk("ovf_2048_line", overflow, 0);
        for (int c = 0; c < 2049; c++) step(1, 12'($urandom), 0, (c == 2048), 1);
        idle(3);
        chk("ovf_2049_sticky", overflow, 1);
        step(0, 0, 0, 0, 0);
        chk("ovf_cleared", overflow, 0);

        n_win = 0;
        send_frame(4, 4, 30, 1, -1);
        idle(4);
        chk("win_count_recover", n_win, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
